// File: rtl/fp_to_fix_pipe.sv
// fp_to_fix_pipe: 3-stage float to signed fixed-point converter with selectable rounding,
// saturation, per-result flags and a saturating overflow counter.
module fp_to_fix_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int INT_W     = 32,
    parameter int FRAC_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   flt_value,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INT_W-1:0]       int_val,
    output logic                   pos,
    output logic [3:0]             flags,
    output logic [15:0]            sat_cnt
);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int SH_W = EXP_W + $clog2(MAN_W + FRAC_BITS + 2) + 2;
    localparam int OFS  = BIAS + MAN_W - FRAC_BITS;
    localparam int XW   = 2 * MAN_W + 3;
    localparam int LW   = MAN_W + INT_W + 2;
    localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};
    localparam logic [INT_W:0]   POS_LIM = NEG_LIM - 1'b1;
    localparam logic [INT_W-1:0] MAX_V   = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MIN_V   = {1'b1, {(INT_W-1){1'b0}}};

    logic en;
    logic v1_q, sgn1_q, nan1_q, inf1_q;
    logic [MAN_W:0] mant1_q;
    logic signed [SH_W-1:0] sh1_q;
    logic [1:0] rnd1_q;
    logic v2_q, sgn2_q, nan2_q, inf2_q, big2_q, g2_q, s2_q;
    logic [INT_W:0] mag2_q;
    logic [1:0] rnd2_q;
    logic v3_q, pos_q;
    logic [INT_W-1:0] val_q;
    logic [3:0] flags_q;
    logic [15:0] sat_q;

    assign en        = ~v3_q | out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign int_val   = val_q;
    assign pos       = pos_q;
    assign flags     = flags_q;
    assign sat_cnt   = sat_q;

    // S1: decode and classify; shift = unbiased exponent + FRAC_BITS - MAN_W
    logic [EXP_W-1:0] exp_f;
    logic exp_max, exp_zero, nan1_d, inf1_d;
    logic [MAN_W:0] mant1_d;
    logic signed [SH_W-1:0] sh1_d;
    always_comb begin
        exp_f    = flt_value[MAN_W +: EXP_W];
        exp_max  = &exp_f;
        exp_zero = ~|exp_f;
        nan1_d   = exp_max & |flt_value[MAN_W-1:0];
        inf1_d   = exp_max & ~|flt_value[MAN_W-1:0];
        mant1_d  = {~exp_zero, flt_value[MAN_W-1:0]};
        sh1_d    = $signed(SH_W'(exp_zero ? EXP_W'(1) : exp_f)) - SH_W'(OFS);
    end

    // S2: align; right shifts keep a guard bit and OR the rest into sticky
    logic left, far, ovl, big2_d, g2_d, s2_d;
    logic [SH_W-1:0] rs;
    logic [LW-1:0] lsh_w, mag_w;
    logic [XW-1:0] xr;
    always_comb begin
        left   = ~sh1_q[SH_W-1];
        rs     = -sh1_q;
        far    = rs >= SH_W'(MAN_W + 2);
        ovl    = sh1_q > SH_W'(INT_W);
        lsh_w  = LW'(mant1_q) << sh1_q;
        xr     = {mant1_q, {(MAN_W+2){1'b0}}} >> rs;
        mag_w  = left ? lsh_w : far ? '0 : LW'(xr[XW-1:MAN_W+2]);
        big2_d = (left & ovl & |mant1_q) | |mag_w[LW-1:INT_W];
        g2_d   = ~left & ~far & xr[MAN_W+1];
        s2_d   = ~left & (far ? |mant1_q : |xr[MAN_W:0]);
    end

    // S3: round by mode and sign, then saturate and negate
    logic inx, inc, ovf, zero;
    logic [INT_W:0] magr;
    logic [INT_W-1:0] res;
    always_comb begin
        inx  = g2_q | s2_q;
        inc  = rnd2_q[1] ? (rnd2_q[0] ^ sgn2_q) & inx : rnd2_q[0] & g2_q & (s2_q | mag2_q[0]);
        magr = mag2_q + (INT_W+1)'(inc);
        ovf  = ~nan2_q & (inf2_q | big2_q | (magr > (sgn2_q ? NEG_LIM : POS_LIM)));
        res  = nan2_q ? '0 : ovf ? (sgn2_q ? MIN_V : MAX_V) :
               sgn2_q ? -magr[INT_W-1:0] : magr[INT_W-1:0];
        zero = ~nan2_q & ~|res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1_q, sgn1_q, nan1_q, inf1_q, mant1_q, sh1_q, rnd1_q} <= '0;
            {v2_q, sgn2_q, nan2_q, inf2_q, big2_q, g2_q, s2_q, mag2_q, rnd2_q} <= '0;
            {v3_q, pos_q, val_q, flags_q, sat_q} <= '0;
        end else begin
            if (en) begin
                v1_q    <= in_valid;
                sgn1_q  <= flt_value[EXP_W+MAN_W];
                nan1_q  <= nan1_d;
                inf1_q  <= inf1_d;
                mant1_q <= mant1_d;
                sh1_q   <= sh1_d;
                rnd1_q  <= rnd_mode;
                v2_q    <= v1_q;
                sgn2_q  <= sgn1_q;
                nan2_q  <= nan1_q;
                inf2_q  <= inf1_q;
                big2_q  <= big2_d;
                g2_q    <= g2_d;
                s2_q    <= s2_d;
                mag2_q  <= mag_w[INT_W:0];
                rnd2_q  <= rnd1_q;
                v3_q    <= v2_q;
                pos_q   <= ~sgn2_q;
                val_q   <= res;
                flags_q <= {nan2_q, ovf, ~nan2_q & ~inf2_q & inx, zero};
            end
            if (v3_q & out_ready & flags_q[2] & ~&sat_q)
                sat_q <= sat_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_fp_to_fix_pipe.sv
// tb_fp_to_fix_pipe: directed and random checks of fp_to_fix_pipe against a real-arithmetic model.
module tb_fp_to_fix_pipe;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, pos;
    logic [31:0] flt_value = 0, int_val;
    logic [1:0] rnd_mode = 0;
    logic [3:0] flags;
    logic [15:0] sat_cnt;
    int n_chk = 0, n_fail = 0, n_del = 0, idx;
    bit acc;
    logic [36:0] exp_q[$];
    logic [31:0] vec[4] = '{32'h3F800000, 32'hC0200000, 32'h3FC00000, 32'h49742400};
    logic [31:0] r_iv;
    logic r_p;
    logic [3:0] r_fl;

    always #5 clk = ~clk;

    fp_to_fix_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flt_value(flt_value), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .int_val(int_val), .pos(pos), .flags(flags), .sat_cnt(sat_cnt)
    );

    function automatic real pow2(input int k);
        real r = 1.0;
        for (int i = 0; i < (k < 0 ? -k : k); i++) r = (k < 0) ? r / 2.0 : r * 2.0;
        return r;
    endfunction

    // expected {int_val, pos, flags} from the real value of the float
    function automatic logic [36:0] ref_model(input logic [31:0] f, input logic [1:0] m);
        logic s = f[31];
        int e = int'(f[30:23]);
        logic [22:0] man = f[22:0];
        real x, lo, hi, r;
        longint v;
        logic [31:0] iv;
        logic inx;
        if (e == 255)
            return (man != 0) ? {32'h0, ~s, 4'b1000} : {s ? 32'h80000000 : 32'h7FFFFFFF, ~s, 4'b0100};
        x  = (e == 0 ? real'(man) : real'(man) + 8388608.0) * pow2((e == 0 ? -126 : e - 127) - 23 + 12);
        lo = $floor(x);
        hi = $ceil(x);
        case (m)
            2'd0: r = lo;
            2'd1: r = (x - lo > 0.5) ? hi : (x - lo < 0.5) ? lo : ($floor(lo / 2.0) * 2.0 == lo ? lo : hi);
            2'd2: r = s ? hi : lo;
            default: r = s ? lo : hi;
        endcase
        inx = (r != x);
        if (r > (s ? 2147483648.0 : 2147483647.0))
            return {s ? 32'h80000000 : 32'h7FFFFFFF, ~s, 1'b0, 1'b1, inx, 1'b0};
        v  = longint'(r);
        iv = s ? 32'(-v) : 32'(v);
        return {iv, ~s, 2'b00, inx, iv == 0};
    endfunction

    function automatic logic [31:0] rand_flt();
        int r = $urandom_range(0, 9);
        logic s = 1'($urandom);
        logic [22:0] man = 23'($urandom);
        if (r < 6) return {s, 8'($urandom_range(100, 160)), man};
        if (r == 6) return {s, 8'($urandom_range(105, 118)), man & 23'h7F0000};
        if (r == 7) return $urandom;
        if (r == 8) return {s, 8'h00, man};
        return {s, 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : man};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: score handshakes just before the edge, return at edge+1
    task automatic cyc();
        logic [36:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("int_val", int_val, e[36:5]);
                chk("pos", 32'(pos), 32'(e[4]));
                chk("flags", 32'(flags), 32'(e[3:0]));
                n_del++;
            end
        end
        if (acc) exp_q.push_back(ref_model(flt_value, rnd_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input logic [31:0] f, input logic [1:0] m);
        flt_value = f;
        rnd_mode  = m;
        in_valid  = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("run1_valid", 32'(out_valid), 1);
        r_iv = int_val;
        r_p  = pos;
        r_fl = flags;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_int_val", int_val, 0);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_sat_cnt", 32'(sat_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 1);

        // back-to-back with exact latency
        rnd_mode = 2'd1;
        in_valid = 1;
        flt_value = 32'h3F800000;
        @(posedge clk); #1;
        chk("lat_c1", 32'(out_valid), 0);
        flt_value = 32'h3FC00000;
        @(posedge clk); #1;
        chk("lat_c2", 32'(out_valid), 0);
        flt_value = 32'hC0200000;
        @(posedge clk); #1;
        in_valid = 0;
        chk("c3_valid", 32'(out_valid), 1);
        chk("c3_val", int_val, 32'h00001000);
        chk("c3_pos", 32'(pos), 1);
        chk("c3_flags", 32'(flags), 0);
        @(posedge clk); #1;
        chk("c4_val", int_val, 32'h00001800);
        chk("c4_pos", 32'(pos), 1);
        @(posedge clk); #1;
        chk("c5_val", int_val, 32'hFFFFD800);
        chk("c5_pos", 32'(pos), 0);
        chk("c5_flags", 32'(flags), 0);
        @(posedge clk); #1;
        chk("c6_idle", 32'(out_valid), 0);

        // half-LSB in every rounding mode
        for (int m = 0; m < 4; m++) begin
            run1(32'h39000000, 2'(m));
            chk("half_lsb_val", r_iv, (m == 3) ? 32'd1 : 32'd0);
            chk("half_lsb_flags", 32'(r_fl), (m == 3) ? 32'b0010 : 32'b0011);
        end
        run1(32'h39C00000, 2'd1);
        chk("one_half_rne", r_iv, 32'd2);
        chk("one_half_flags", 32'(r_fl), 32'b0010);
        run1(32'h00000001, 2'd3);
        chk("min_dn_ceil", r_iv, 32'd1);
        chk("min_dn_ceil_flags", 32'(r_fl), 32'b0010);
        run1(32'h00000001, 2'd0);
        chk("min_dn_trunc", r_iv, 32'd0);
        chk("min_dn_trunc_flags", 32'(r_fl), 32'b0011);
        run1(32'h80000000, 2'd1);
        chk("neg_zero_val", r_iv, 0);
        chk("neg_zero_pos", 32'(r_p), 0);
        chk("neg_zero_flags", 32'(r_fl), 32'b0001);

        // saturation, infinity, NaN
        run1(32'h49742400, 2'd1);
        chk("big_val", r_iv, 32'h7FFFFFFF);
        chk("big_flags", 32'(r_fl), 32'b0100);
        chk("sat_cnt1", 32'(sat_cnt), 1);
        run1(32'hFF800000, 2'd0);
        chk("ninf_val", r_iv, 32'h80000000);
        chk("ninf_flags", 32'(r_fl), 32'b0100);
        chk("sat_cnt2", 32'(sat_cnt), 2);
        run1(32'h7FC00000, 2'd0);
        chk("nan_val", r_iv, 0);
        chk("nan_flags", 32'(r_fl), 32'b1000);
        chk("sat_cnt_nan", 32'(sat_cnt), 2);

        // stall: 4 offered while out_ready low for 5 cycles
        n_del = 0;
        idx = 0;
        rnd_mode = 2'd1;
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            flt_value = vec[idx];
            cyc();
            if (acc) idx++;
            if (out_valid) chk("stall_hold", int_val, exp_q[0][36:5]);
        end
        chk("stall_accepted", idx, 3);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        out_ready = 1;
        for (int i = 0; i < 10 && idx < 4; i++) begin
            flt_value = vec[idx];
            cyc();
            if (acc) idx++;
        end
        in_valid = 0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        cyc();
        chk("stall_delivered", n_del, 4);
        chk("stall_drained", 32'(out_valid), 0);

        // reset with three results in flight
        out_ready = 0;
        in_valid = 1;
        flt_value = 32'h49742400;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_val", int_val, 0);
        chk("mid_rst_flags", 32'(flags), 0);
        chk("mid_rst_sat", 32'(sat_cnt), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale", 32'(out_valid), 0);
        end
        chk("post_rst_sat", 32'(sat_cnt), 0);

        // random traffic with random backpressure
        exp_q.delete();
        n_del = 0;
        acc = 0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || acc) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                flt_value = rand_flt();
                rnd_mode  = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        chk("rand_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
